// File: rtl/decode_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and register-read.
// master drives instructions and consumes decoded fields; slave is the decode stage.
interface decode_if #(
  parameter int INSTR_W = 8,
  parameter int OPC_W   = 4,
  parameter int REG_AW  = 3
) ();
  localparam int FIELD_W = (INSTR_W - OPC_W) / 2;
  localparam int WORD_W  = INSTR_W - OPC_W;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         alu_op;
  logic [REG_AW-1:0]  rs1;
  logic [REG_AW-1:0]  rs2;
  logic [REG_AW-1:0]  rd;
  logic [FIELD_W-1:0] imm;
  logic [WORD_W-1:0]  branch_addr;
  logic               mem_rd;
  logic               mem_wr;
  logic               label_rd;
  logic               reg_wr;
  logic               branch;
  logic               jump;
  logic               halted;

  modport master (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, alu_op, rs1, rs2, rd, imm, branch_addr,
    input  mem_rd, mem_wr, label_rd, reg_wr, branch, jump, halted
  );

  modport slave (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, alu_op, rs1, rs2, rd, imm, branch_addr,
    output mem_rd, mem_wr, label_rd, reg_wr, branch, jump, halted
  );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction-decode stage: one instruction in, one decoded bundle out,
// valid/ready on both sides, flush for taken branches and a sticky halt.
module decode_stage #(
  parameter int INSTR_W = 8,
  parameter int OPC_W   = 4,
  parameter int REG_AW  = 3,
  parameter int V0_REG  = 4,
  parameter int RC_REG  = 5
) (
  input  logic    clk,
  input  logic    rst_n,
  decode_if.slave bus
);
  localparam int FIELD_W = (INSTR_W - OPC_W) / 2;
  localparam int WORD_W  = INSTR_W - OPC_W;
  localparam logic [REG_AW-1:0] V0 = REG_AW'(V0_REG);
  localparam logic [REG_AW-1:0] RC = REG_AW'(RC_REG);

  typedef struct packed {
    logic [3:0]         alu_op;
    logic [REG_AW-1:0]  rs1;
    logic [REG_AW-1:0]  rs2;
    logic [REG_AW-1:0]  rd;
    logic [FIELD_W-1:0] imm;
    logic [WORD_W-1:0]  baddr;
    logic               mem_rd;
    logic               mem_wr;
    logic               label_rd;
    logic               reg_wr;
    logic               branch;
    logic               jump;
  } dec_t;

  // Every opcode writes every field; unused fields stay at the cleared default.
  function automatic dec_t decode(input logic [INSTR_W-1:0] ins);
    dec_t              d;
    logic [REG_AW-1:0] a;
    logic [REG_AW-1:0] b;
    logic [REG_AW-1:0] w;
    logic [31:0]       opc;
    d   = '0;
    a   = REG_AW'(ins[2*FIELD_W-1:FIELD_W]);
    b   = REG_AW'(ins[FIELD_W-1:0]);
    w   = REG_AW'(ins[WORD_W-1:0]);
    opc = 32'(ins[INSTR_W-1 -: OPC_W]);
    case (opc)
      32'd0:  begin d.alu_op = 4'b0000; d.rs1 = a; d.rs2 = b; d.rd = a; d.reg_wr = 1'b1; end
      32'd1:  begin
        d.alu_op = 4'b0001; d.rs1 = a; d.rd = a; d.reg_wr = 1'b1;
        d.imm    = ins[FIELD_W-1:0];
      end
      32'd2:  begin
        d.alu_op = 4'b1111; d.rs2 = b; d.rd = a; d.reg_wr = 1'b1; d.mem_rd = 1'b1;
      end
      32'd3:  begin d.alu_op = 4'b1100; d.rs1 = a; d.rs2 = b; d.mem_wr = 1'b1; end
      32'd4:  begin
        d.alu_op = 4'b0011; d.rs1 = a; d.rd = a; d.reg_wr = 1'b1;
        d.imm    = ins[FIELD_W-1:0];
      end
      32'd5:  begin d.alu_op = 4'b1101; d.rs1 = a; d.rs2 = b; d.rd = V0; d.reg_wr = 1'b1; end
      32'd6:  begin
        d.alu_op = 4'b0101; d.rs2 = V0; d.branch = 1'b1; d.label_rd = 1'b1;
        d.baddr  = ins[WORD_W-1:0];
      end
      32'd7:  begin
        d.alu_op = 4'b1011; d.jump = 1'b1; d.label_rd = 1'b1;
        d.baddr  = ins[WORD_W-1:0];
      end
      32'd8:  begin d.alu_op = 4'b0010; d.rs1 = a; d.rs2 = b; d.rd = a; d.reg_wr = 1'b1; end
      32'd9:  begin d.alu_op = 4'b1100; d.rs1 = w; d.rd = V0; d.reg_wr = 1'b1; end
      32'd10: begin d.alu_op = 4'b1100; d.rs1 = V0; d.rd = w; d.reg_wr = 1'b1; end
      32'd11: begin d.alu_op = 4'b0000; d.rs1 = a; d.rs2 = RC; d.rd = a; d.reg_wr = 1'b1; end
      32'd12: begin d.alu_op = 4'b1000; d.rs1 = w; d.rd = w; d.reg_wr = 1'b1; end
      32'd13: begin d.alu_op = 4'b0110; d.rs1 = a; d.rs2 = b; d.rd = V0; d.reg_wr = 1'b1; end
      32'd14: begin d.alu_op = 4'b0000; end
      32'd15: begin d.alu_op = 4'b1110; d.rs1 = a; d.rd = a; d.reg_wr = 1'b1; end
      // Opcodes beyond the base 16 (wide OPC_W) behave as an add that writes nothing.
      default: begin d.alu_op = 4'b0000; d.rs1 = a; d.rs2 = b; d.rd = a; d.reg_wr = 1'b0; end
    endcase
    return d;
  endfunction

  logic out_valid_q, out_valid_d;
  logic halted_q, halted_d;
  dec_t dec_q, dec_d;
  logic in_ready_s;
  logic accept_s;
  logic consume_s;
  logic is_halt_s;

  assign in_ready_s = !halted_q && (!out_valid_q || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign consume_s  = out_valid_q && bus.out_ready;
  assign is_halt_s  = (32'(bus.instr[INSTR_W-1 -: OPC_W]) == 32'd14);

  // Next-state: flush beats accept; fields only reload when an instruction is taken.
  always_comb begin
    out_valid_d = out_valid_q;
    dec_d       = dec_q;
    halted_d    = halted_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept_s) begin
      out_valid_d = 1'b1;
      dec_d       = decode(bus.instr);
      halted_d    = halted_q || is_halt_s;
    end else if (consume_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output and state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      dec_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      dec_q       <= dec_d;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_q;
  assign bus.halted      = halted_q;
  assign bus.alu_op      = dec_q.alu_op;
  assign bus.rs1         = dec_q.rs1;
  assign bus.rs2         = dec_q.rs2;
  assign bus.rd          = dec_q.rd;
  assign bus.imm         = dec_q.imm;
  assign bus.branch_addr = dec_q.baddr;
  assign bus.mem_rd      = dec_q.mem_rd;
  assign bus.mem_wr      = dec_q.mem_wr;
  assign bus.label_rd    = dec_q.label_rd;
  assign bus.reg_wr      = dec_q.reg_wr;
  assign bus.branch      = dec_q.branch;
  assign bus.jump        = dec_q.jump;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage at default parameters; expected words come from
// a hand-written opcode table model.
module tb_decode_stage;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  decode_if #(.INSTR_W(8), .OPC_W(4), .REG_AW(3)) bus ();

  decode_stage #(.INSTR_W(8), .OPC_W(4), .REG_AW(3), .V0_REG(4), .RC_REG(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed {out_valid, alu_op, rs1, rs2, rd, imm, branch_addr, mr, mw, lr, rw, br, jp}
  function automatic logic [31:0] model(input logic [7:0] ins);
    logic [3:0] op;
    logic [3:0] alu;
    logic [2:0] a, b, w, s1, s2, d;
    logic [1:0] im;
    logic [3:0] ba;
    logic mr, mw, lr, rw, br, jp;
    op = ins[7:4];
    a  = {1'b0, ins[3:2]};
    b  = {1'b0, ins[1:0]};
    w  = ins[2:0];
    alu = 4'd0; s1 = 3'd0; s2 = 3'd0; d = 3'd0; im = 2'd0; ba = 4'd0;
    mr = 1'b0; mw = 1'b0; lr = 1'b0; rw = 1'b0; br = 1'b0; jp = 1'b0;
    case (op)
      4'd0:  begin alu = 4'b0000; s1 = a; s2 = b; d = a; rw = 1'b1; end
      4'd1:  begin alu = 4'b0001; s1 = a; d = a; rw = 1'b1; im = ins[1:0]; end
      4'd2:  begin alu = 4'b1111; s2 = b; d = a; rw = 1'b1; mr = 1'b1; end
      4'd3:  begin alu = 4'b1100; s1 = a; s2 = b; mw = 1'b1; end
      4'd4:  begin alu = 4'b0011; s1 = a; d = a; rw = 1'b1; im = ins[1:0]; end
      4'd5:  begin alu = 4'b1101; s1 = a; s2 = b; d = 3'd4; rw = 1'b1; end
      4'd6:  begin alu = 4'b0101; s2 = 3'd4; br = 1'b1; lr = 1'b1; ba = ins[3:0]; end
      4'd7:  begin alu = 4'b1011; jp = 1'b1; lr = 1'b1; ba = ins[3:0]; end
      4'd8:  begin alu = 4'b0010; s1 = a; s2 = b; d = a; rw = 1'b1; end
      4'd9:  begin alu = 4'b1100; s1 = w; d = 3'd4; rw = 1'b1; end
      4'd10: begin alu = 4'b1100; s1 = 3'd4; d = w; rw = 1'b1; end
      4'd11: begin alu = 4'b0000; s1 = a; s2 = 3'd5; d = a; rw = 1'b1; end
      4'd12: begin alu = 4'b1000; s1 = w; d = w; rw = 1'b1; end
      4'd13: begin alu = 4'b0110; s1 = a; s2 = b; d = 3'd4; rw = 1'b1; end
      4'd14: begin alu = 4'b0000; end
      4'd15: begin alu = 4'b1110; s1 = a; d = a; rw = 1'b1; end
      default: begin alu = 4'b0000; end
    endcase
    return 32'({1'b1, alu, s1, s2, d, im, ba, mr, mw, lr, rw, br, jp});
  endfunction

  function automatic logic [31:0] dut_word();
    return 32'({bus.out_valid, bus.alu_op, bus.rs1, bus.rs2, bus.rd, bus.imm, bus.branch_addr,
                bus.mem_rd, bus.mem_wr, bus.label_rd, bus.reg_wr, bus.branch, bus.jump});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.instr     = 8'h00;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    chk("reset_word", dut_word(), 32'd0);
    chk("reset_halted", 32'(bus.halted), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    #10;
    rst_n = 1'b1;

    bus.instr = 8'h07; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    chk("add_word", dut_word(), model(8'h07));
    chk("add_rs2", 32'(bus.rs2), 32'd3);
    chk("add_reg_wr", 32'(bus.reg_wr), 32'd1);

    bus.out_ready = 1'b0; bus.instr = 8'h16;
    #1;
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (3) tick();
    chk("stall_hold", dut_word(), model(8'h07));
    bus.out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("addi_word", dut_word(), model(8'h16));
    chk("addi_imm", 32'(bus.imm), 32'd2);

    bus.instr = 8'h6A;
    tick();
    chk("beq0_word", dut_word(), model(8'h6A));
    chk("beq0_addr", 32'(bus.branch_addr), 32'hA);
    chk("beq0_flags", 32'({bus.branch, bus.label_rd, bus.reg_wr, bus.rs2}), 32'({3'b110, 3'd4}));

    bus.instr = 8'h75;
    tick();
    chk("j_word", dut_word(), model(8'h75));
    chk("j_flags", 32'({bus.jump, bus.branch}), 32'b10);

    bus.instr = 8'h80; bus.flush = 1'b1;
    tick();
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    bus.flush = 1'b0; bus.instr = 8'hC3;
    tick();
    chk("clr_word", dut_word(), model(8'hC3));
    chk("clr_fields", 32'({bus.rd, bus.alu_op}), 32'({3'd3, 4'b1000}));

    for (int i = 0; i < 224; i++) begin
      bus.instr = 8'(i);
      tick();
      chk("stream", dut_word(), model(8'(i)));
    end

    bus.instr = 8'hE0; bus.flush = 1'b1;
    tick();
    chk("halt_flushed", 32'({bus.halted, bus.out_valid}), 32'd0);
    bus.flush = 1'b0;
    tick();
    chk("halt_word", dut_word(), model(8'hE0));
    chk("halt_set", 32'(bus.halted), 32'd1);
    chk("halt_in_ready", 32'(bus.in_ready), 32'd0);
    bus.instr = 8'h07;
    repeat (2) tick();
    chk("halt_drained", 32'({bus.halted, bus.out_valid, bus.in_ready}), 32'b100);

    #3; rst_n = 1'b0;
    #1;
    chk("rst_halted", 32'({bus.halted, bus.in_ready}), 32'b01);
    #2; rst_n = 1'b1;

    bus.instr = 8'h5B; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    chk("stl_word", dut_word(), model(8'h5B));
    bus.in_valid = 1'b0;
    #3; rst_n = 1'b0;
    #1;
    chk("async_rst_word", dut_word(), 32'd0);
    #2; rst_n = 1'b1;

    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int i = 240; i < 256; i++) begin
      bus.instr = 8'(i);
      tick();
      chk("stream_hi", dut_word(), model(8'(i)));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
